// File: rtl/song_player_if.sv
// rtl/song_player_if.sv - control, note-memory write and status bundle for song_player
//
// Signals (direction seen from the master, i.e. the controlling side):
//   tick        out  single-cycle beat pulse
//   play        out  level: run / stop-and-rewind
//   pause       out  level: hold position, output rest
//   loop        out  sampled at end of song: restart slot or stop
//   song_sel    out  slot to play, sampled when leaving IDLE
//   wr_en       out  note memory write strobe
//   wr_addr     out  note memory write address
//   wr_data     out  {note, duration}, note in MSBs
//   note        in   current note code
//   note_start  in   one-cycle pulse when a new note is presented
//   busy        in   sequencer is fetching or playing
//   done        in   sequencer reached end of a one-shot song
//   pos         in   address of current entry
interface song_player_if #(
    parameter int NOTE_W = 5,
    parameter int DUR_W  = 4,
    parameter int ADDR_W = 8,
    parameter int SONG_W = 2
);
    logic                     tick;
    logic                     play;
    logic                     pause;
    logic                     loop;
    logic [SONG_W-1:0]        song_sel;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [NOTE_W+DUR_W-1:0]  wr_data;
    logic [NOTE_W-1:0]        note;
    logic                     note_start;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        pos;

    modport master (
        output tick, play, pause, loop, song_sel, wr_en, wr_addr, wr_data,
        input  note, note_start, busy, done, pos
    );

    modport slave (
        input  tick, play, pause, loop, song_sel, wr_en, wr_addr, wr_data,
        output note, note_start, busy, done, pos
    );
endinterface

// File: rtl/song_player.sv
// rtl/song_player.sv - slotted note-memory song sequencer with pause, loop and note-start pulse
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   io_bus  slave modport of song_player_if (controls, memory write port, status outputs)
module song_player #(
    parameter int                NOTE_W    = 5,
    parameter int                DUR_W     = 4,
    parameter int                ADDR_W    = 8,
    parameter int                SONG_W    = 2,
    parameter logic [NOTE_W-1:0] REST_CODE = 5'b10101
) (
    input  logic          clk,
    input  logic          rst_n,
    song_player_if.slave  io_bus
);
    localparam int ENTRY_W = NOTE_W + DUR_W;
    localparam int OFF_W   = ADDR_W - SONG_W;
    localparam int DEPTH   = 2**ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_PAUSED,
        S_DONE
    } state_t;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rd_data;

    state_t             r_state;
    logic [NOTE_W-1:0]  r_note;
    logic [NOTE_W-1:0]  r_cur_note;
    logic               r_note_start;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_pos;
    logic [DUR_W-1:0]   r_remaining;
    logic [SONG_W-1:0]  r_slot;

    logic [NOTE_W-1:0]  w_entry_note;
    logic [DUR_W-1:0]   w_entry_dur;
    logic [ADDR_W-1:0]  w_base;
    logic [ADDR_W-1:0]  w_sel_base;
    logic               w_at_base;
    logic               w_seg_last;

    assign w_entry_note = r_rd_data[ENTRY_W-1 -: NOTE_W];
    assign w_entry_dur  = r_rd_data[DUR_W-1:0];
    assign w_base       = {r_slot, {OFF_W{1'b0}}};
    assign w_sel_base   = {io_bus.song_sel, {OFF_W{1'b0}}};
    assign w_at_base    = (r_pos == w_base);
    assign w_seg_last   = &r_pos[OFF_W-1:0];

    // Read is addressed by pos every cycle: the entry set up on entry to
    // FETCH is captured at the FETCH edge and examined in LOAD. A write to
    // the same address in the same cycle leaves the old word on the read port.
    always_ff @(posedge clk) begin
        if (io_bus.wr_en) begin
            r_mem[io_bus.wr_addr] <= io_bus.wr_data;
        end
        r_rd_data <= r_mem[r_pos];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_note       <= REST_CODE;
            r_cur_note   <= REST_CODE;
            r_note_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pos        <= '0;
            r_remaining  <= '0;
            r_slot       <= '0;
        end else begin
            r_note_start <= 1'b0;
            if (!io_bus.play) begin
                // Stop overrides everything: rewind to the latched slot base.
                r_state     <= S_IDLE;
                r_note      <= REST_CODE;
                r_pos       <= w_base;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_slot  <= io_bus.song_sel;
                        r_pos   <= w_sel_base;
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        if (w_entry_dur == '0) begin
                            // A marker at the base is an empty song and never loops.
                            if (!w_at_base && io_bus.loop) begin
                                r_pos   <= w_base;
                                r_state <= S_FETCH;
                            end else begin
                                r_state <= S_DONE;
                                r_note  <= REST_CODE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_note       <= w_entry_note;
                            r_cur_note   <= w_entry_note;
                            r_remaining  <= w_entry_dur;
                            r_note_start <= 1'b1;
                            r_state      <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (io_bus.pause) begin
                            r_state <= S_PAUSED;
                            r_note  <= REST_CODE;
                        end else if (io_bus.tick) begin
                            r_remaining <= r_remaining - DUR_W'(1);
                            if (r_remaining == DUR_W'(1)) begin
                                if (!w_seg_last) begin
                                    r_pos   <= r_pos + ADDR_W'(1);
                                    r_state <= S_FETCH;
                                end else if (io_bus.loop) begin
                                    // Last slot entry played: wrap within the slot only.
                                    r_pos   <= w_base;
                                    r_state <= S_FETCH;
                                end else begin
                                    r_state <= S_DONE;
                                    r_note  <= REST_CODE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (!io_bus.pause) begin
                            r_note  <= r_cur_note;
                            r_state <= S_PLAY;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_note  <= REST_CODE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.note       = r_note;
    assign io_bus.note_start = r_note_start;
    assign io_bus.busy       = r_busy;
    assign io_bus.done       = r_done;
    assign io_bus.pos        = r_pos;
endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - self-checking bench for song_player against a note-list reference model
module tb_song_player;
    localparam int NOTE_W = 5;
    localparam int DUR_W  = 4;
    localparam int ADDR_W = 8;
    localparam int SONG_W = 2;
    localparam int SEG    = 2**(ADDR_W-SONG_W);
    localparam int REST   = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    song_player_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .SONG_W(SONG_W)) sp_if ();

    song_player #(
        .NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W), .SONG_W(SONG_W), .REST_CODE(5'b10101)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (sp_if)
    );

    typedef struct {
        int note;
        int dur;
        int pos;
        int lat;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mem_model [2**ADDR_W];
    exp_t exp_q [$];
    bit   ended;
    int   end_lat;

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input int note, input int dur);
        logic [4:0] n5;
        logic [3:0] d4;
        n5 = 5'(note);
        d4 = 4'(dur);
        sp_if.wr_en   = 1'b1;
        sp_if.wr_addr = 8'(addr);
        sp_if.wr_data = {n5, d4};
        mem_model[addr] = note * 16 + dur;
        step();
        sp_if.wr_en = 1'b0;
    endtask

    // Walks the slot as a list of entries: each note records the cycles from
    // its trigger (play or the ending tick of the previous note) to its start.
    // Passing an end marker while looping costs one extra fetch/examine pair.
    task automatic build_expected(input int base, input bit loop_v, input int max_notes);
        int off;
        int lat;
        int e;
        exp_t x;
        exp_q.delete();
        ended = 0;
        end_lat = 0;
        off = 0;
        lat = 3;
        while (exp_q.size() < max_notes && !ended) begin
            e = mem_model[base + off];
            if (e % 16 == 0) begin
                if (off == 0 || !loop_v) begin
                    ended = 1;
                    end_lat = lat;
                end else begin
                    off = 0;
                    lat += 2;
                end
            end else begin
                x.note = e / 16;
                x.dur  = e % 16;
                x.pos  = base + off;
                x.lat  = lat;
                exp_q.push_back(x);
                lat = 3;
                if (off == SEG - 1) begin
                    if (loop_v) off = 0;
                    else begin
                        ended = 1;
                        end_lat = 1;
                    end
                end else begin
                    off++;
                end
            end
        end
    endtask

    task automatic run_song(input int slot, input bit loop_v, input int max_notes, input int period);
        int prev_note;
        prev_note = -1;
        build_expected(slot * SEG, loop_v, max_notes);
        sp_if.song_sel = 2'(slot);
        sp_if.loop     = loop_v;
        sp_if.play     = 1'b1;
        foreach (exp_q[i]) begin
            for (int s = 1; s <= exp_q[i].lat; s++) begin
                step();
                sp_if.tick = 1'b0;
                if (s < exp_q[i].lat) begin
                    chk("gap_no_start", sp_if.note_start, 0);
                    if (prev_note >= 0) chk("gap_hold_note", sp_if.note, prev_note);
                end else begin
                    chk("note_start", sp_if.note_start, 1);
                    chk("note", sp_if.note, exp_q[i].note);
                    chk("pos", sp_if.pos, exp_q[i].pos);
                    chk("busy", sp_if.busy, 1);
                end
            end
            prev_note = exp_q[i].note;
            for (int t = 1; t <= exp_q[i].dur; t++) begin
                repeat (period - 1) begin
                    step();
                    chk("hold_note", sp_if.note, prev_note);
                    chk("no_restart", sp_if.note_start, 0);
                end
                sp_if.tick = 1'b1;
                if (t < exp_q[i].dur) begin
                    step();
                    sp_if.tick = 1'b0;
                    chk("mid_note", sp_if.note, prev_note);
                end
            end
        end
        if (ended) begin
            for (int s = 1; s <= end_lat; s++) begin
                step();
                sp_if.tick = 1'b0;
                chk("end_no_start", sp_if.note_start, 0);
                if (s < end_lat) chk("done_early", sp_if.done, 0);
                else begin
                    chk("done", sp_if.done, 1);
                    chk("done_busy", sp_if.busy, 0);
                    chk("done_note", sp_if.note, REST);
                end
            end
        end
    endtask

    task automatic stop_and_check(input int base);
        sp_if.play = 1'b0;
        step();
        sp_if.tick = 1'b0;
        chk("stop_note", sp_if.note, REST);
        chk("stop_busy", sp_if.busy, 0);
        chk("stop_done", sp_if.done, 0);
        chk("stop_pos", sp_if.pos, base);
        chk("stop_no_start", sp_if.note_start, 0);
        step();
    endtask

    task automatic tick_and_wait(input int gap);
        sp_if.tick = 1'b1;
        step();
        sp_if.tick = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        int n;
        bit lv;
        sp_if.tick = 0; sp_if.play = 0; sp_if.pause = 0; sp_if.loop = 0;
        sp_if.song_sel = 0; sp_if.wr_en = 0; sp_if.wr_addr = 0; sp_if.wr_data = 0;
        for (int a = 0; a < 2**ADDR_W; a++) mem_model[a] = 0;

        // Reset and idle
        repeat (3) step();
        chk("rst_note", sp_if.note, REST);
        chk("rst_busy", sp_if.busy, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("idle_note", sp_if.note, REST);
            chk("idle_busy", sp_if.busy, 0);
            chk("idle_done", sp_if.done, 0);
            chk("idle_pos", sp_if.pos, 0);
        end

        // Directed one-shot song in slot 0
        write_entry(0, 8, 2);
        write_entry(1, 9, 4);
        write_entry(2, 7, 1);
        write_entry(3, 3, 0);
        run_song(0, 0, 64, 4);
        repeat (4) begin
            step();
            chk("done_stays", sp_if.done, 1);
        end
        stop_and_check(0);

        // Random songs in slot 0, random loop mode and tick spacing
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(1, 8);
            lv = 1'($urandom_range(0, 1));
            for (int k = 0; k < n; k++)
                write_entry(k, $urandom_range(0, 31), $urandom_range(1, 3));
            write_entry(n, $urandom_range(0, 31), 0);
            run_song(0, lv, lv ? 2 * n + 1 : 64, $urandom_range(3, 6));
            stop_and_check(0);
        end

        // Slot 1 full of notes, no marker: must wrap inside the slot
        for (int k = 0; k < SEG; k++) write_entry(SEG + k, 5, 1);
        run_song(1, 1, SEG + 6, 3);
        stop_and_check(SEG);

        // Pause with 2 ticks remaining
        write_entry(2 * SEG, 12, 4);
        write_entry(2 * SEG + 1, 0, 0);
        sp_if.song_sel = 2; sp_if.loop = 0; sp_if.play = 1;
        repeat (3) step();
        chk("pz_start", sp_if.note_start, 1);
        chk("pz_note", sp_if.note, 12);
        tick_and_wait(2);
        tick_and_wait(2);
        sp_if.pause = 1'b1;
        step();
        chk("pz_rest", sp_if.note, REST);
        chk("pz_busy", sp_if.busy, 1);
        for (int k = 0; k < 10; k++) begin
            tick_and_wait(2);
            chk("pz_hold_rest", sp_if.note, REST);
            chk("pz_pos", sp_if.pos, 2 * SEG);
            chk("pz_no_start", sp_if.note_start, 0);
        end
        sp_if.pause = 1'b0;
        step();
        chk("pz_resume_note", sp_if.note, 12);
        chk("pz_resume_no_start", sp_if.note_start, 0);
        tick_and_wait(2);
        chk("pz_one_left", sp_if.note, 12);
        chk("pz_not_done", sp_if.done, 0);
        tick_and_wait(2);
        chk("pz_done", sp_if.done, 1);
        stop_and_check(2 * SEG);

        // Empty song with loop set ends without a note
        write_entry(2 * SEG, 12, 0);
        run_song(2, 1, 8, 3);
        stop_and_check(2 * SEG);

        // Edit the next entry while the current one plays
        write_entry(3 * SEG, 3, 2);
        write_entry(3 * SEG + 1, 4, 2);
        write_entry(3 * SEG + 2, 0, 0);
        sp_if.song_sel = 3; sp_if.loop = 0; sp_if.play = 1;
        repeat (3) step();
        chk("ed_note", sp_if.note, 3);
        step();
        write_entry(3 * SEG + 1, 17, 2);
        tick_and_wait(2);
        sp_if.tick = 1'b1;
        step();
        sp_if.tick = 1'b0;
        chk("ed_hold1", sp_if.note, 3);
        step();
        chk("ed_hold2", sp_if.note, 3);
        step();
        chk("ed_start", sp_if.note_start, 1);
        chk("ed_new_note", sp_if.note, 17);
        chk("ed_pos", sp_if.pos, 3 * SEG + 1);
        stop_and_check(3 * SEG);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/song_player.md
# song_player

Parametrised song sequencer that plays note sequences from an internal, writable note memory. It replaces the fixed per-song case-table sequencers. Each entry holds a note code and a duration in beat ticks. It supports multiple song slots, pause/resume, loop or one-shot playback, and a note-start pulse for envelope retrigger. It sits between the beat-tick generator and the tone generator, driving the same 5-bit note code the tone generator already decodes.

## Interface
- NOTE_W, 5, note code width
- DUR_W, 4, duration field width in beat ticks; duration 0 = end marker
- ADDR_W, 8, note memory address width; depth = 2**ADDR_W
- SONG_W, 2, song select width; 2**SONG_W equal slots of SEG = 2**(ADDR_W-SONG_W) entries
- REST_CODE, 5'b10101, note code output when silent
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  single-cycle beat pulse; spacing ≥ 3 clk cycles
- play  in  1  level; high = run, low = stop and rewind
- pause  in  1  level; high = hold position, output rest
- loop  in  1  sampled at each end-of-song: 1 = restart slot, 0 = stop
- song_sel  in  SONG_W  slot to play; sampled on IDLE→FETCH
- wr_en  in  1  memory write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  NOTE_W+DUR_W  {note, duration}; note in MSBs
- note  out  NOTE_W  current note code (registered)
- note_start  out  1  one-cycle pulse when a new note is presented
- busy  out  1  high in FETCH/LOAD/PLAY/PAUSED
- done  out  1  high in DONE
- pos  out  ADDR_W  address of current entry

## Operation
- Memory: DEPTH × (NOTE_W+DUR_W), synchronous write, synchronous read (data valid one cycle after address). Write and read at the same address in the same cycle returns old data. Writes are allowed at any time. An edited entry takes effect the next time it is fetched.
- Slot base = song_sel × SEG.
- States: IDLE, FETCH, LOAD, PLAY, PAUSED, DONE.
- IDLE: note=REST_CODE. When play=1: latch song_sel, set pos=base, go to FETCH.
- FETCH: present pos to memory, go to LOAD.
- LOAD: examine the entry.
  - If duration = 0 and pos = base: empty song, go to DONE regardless of loop.
  - Else if duration = 0: end of song. If loop=1, pos=base and go to FETCH. Otherwise go to DONE.
  - Else: note=entry note, remaining=duration, pulse note_start, go to PLAY.
- PLAY:
  - On tick: decrement remaining. On the tick where remaining=1, go to FETCH with pos=pos+1. The note holds through FETCH/LOAD.
  - If pos offset = SEG-1 when advancing, treat as end of song: apply the loop/DONE rule without fetching, so there is no wrap into the next slot.
- PAUSED: entered from PLAY when pause=1. note=REST_CODE, ticks ignored, remaining frozen. When pause=0, restore the stored note and return to PLAY with no note_start pulse.
- Pause asserted in FETCH/LOAD takes effect on the first PLAY cycle: the entry loads, note_start pulses, then the block enters PAUSED next cycle.
- DONE: note=REST_CODE, done=1. Stays in DONE while play=1. When play=0, go to IDLE.
- play=0 in any state: go to IDLE next cycle, note=REST_CODE, pos=base of the latched slot, no note_start. This has priority over pause, tick and end-of-song.
- Ticks arriving in FETCH/LOAD/IDLE/DONE are dropped.

## Timing
- Reset values: state=IDLE, note=REST_CODE, note_start=0, busy=0, done=0, pos=0, remaining=0, latched slot=0.
- play rising to first note: play high at cycle N → FETCH at N+1 → LOAD at N+2 → note valid and note_start=1 at N+3.
- Note-to-note gap: the tick that ends a note is at cycle T. The next note is presented at T+3 (FETCH T+1, LOAD T+2). The old note is held until then, so there is no rest glitch.
- Note length = duration ticks, measured from the first tick after note_start.
- Loop restart: the end marker in LOAD at cycle L → FETCH of base at L+1 → first note at L+3.
- busy and done are registered, and change on the same edge as the state.

## Test plan
- Reset/idle: hold rst_n=0, then release with play=0 → note=5'b10101, busy=0, done=0, pos=0 for 20 cycles.
- One-shot: slot 0 = {8,2},{9,4},{7,1},{x,0}, loop=0, tick every 4 clk → notes 8, 9, 7 for 2, 4 and 1 ticks. note_start pulses three times, each 3 cycles after the ending tick. Then done=1 and note=REST.
- Loop and segment bound: slot 1 filled with all SEG entries of {5,1} and no marker, loop=1 → pos runs from 64 to 127, then returns to 64. It never reaches 128.
- Pause: pause=1 mid-note with 2 ticks remaining, 10 ticks pass → note=REST, pos unchanged. pause=0 → same note resumes with no note_start, and ends after 2 more ticks.
- Stop mid-play: play=0 during PLAY → IDLE next cycle, note=REST. play=1 again → restarts at slot base.
- Edge cases: song with the end marker at base and loop=1 → DONE within 3 cycles, with no note_start. A write to pos+1 during PLAY → the new value is played.
